// File: rtl/baud_rate_gen.sv
// baud_rate_gen: divides the system clock into a 50 % duty-cycle baud clock
// for the UART transmitter. BaudRate selects 2400/4800/9600/19200 baud.
// BaudOut toggles every HALF = CLK_FREQ / (2*baud) cycles. A change of
// BaudRate restarts the half-period count and leaves the output level alone,
// so a rate change never produces a short (runt) half-period.
// Optional macro BAUD_TICK_EN adds BaudTick, a one-cycle pulse that is high
// in the first cycle BaudOut reads 1 after each 0->1 toggle.
module baud_rate_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CNT_W    = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] BaudRate,
`ifdef BAUD_TICK_EN
    output logic       BaudTick,
`endif
    output logic       BaudOut
);

    localparam logic [CNT_W-1:0] HALF_2400  = CNT_W'(CLK_FREQ / (2 * 2400));
    localparam logic [CNT_W-1:0] HALF_4800  = CNT_W'(CLK_FREQ / (2 * 4800));
    localparam logic [CNT_W-1:0] HALF_9600  = CNT_W'(CLK_FREQ / (2 * 9600));
    localparam logic [CNT_W-1:0] HALF_19200 = CNT_W'(CLK_FREQ / (2 * 19200));

    logic [1:0]       baud_rate_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half, half_m1;
    logic             baud_q, baud_d;
    logic             rate_chg;
`ifdef BAUD_TICK_EN
    logic             tick_q, tick_d;
`endif

    // Half-period lookup, driven from the registered rate so a raw input
    // change cannot disturb the terminal-count compare mid-cycle.
    always_comb begin
        half = HALF_2400;
        unique case (baud_rate_q)
            2'b00:   half = HALF_2400;
            2'b01:   half = HALF_4800;
            2'b10:   half = HALF_9600;
            default: half = HALF_19200;
        endcase
        half_m1 = half - CNT_W'(1);
    end

    // Next-state: restart on rate change, otherwise count and toggle at HALF-1.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        baud_d   = baud_q;
        rate_chg = (BaudRate != baud_rate_q);
`ifdef BAUD_TICK_EN
        tick_d   = 1'b0;
`endif
        if (rate_chg) begin
            cnt_d = '0;
        end else if (cnt_q == half_m1) begin
            cnt_d  = '0;
            baud_d = ~baud_q;
`ifdef BAUD_TICK_EN
            tick_d = ~baud_q;
`endif
        end
    end

    // State registers with synchronous, highest-priority reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q       <= '0;
            baud_q      <= 1'b0;
            baud_rate_q <= BaudRate;
`ifdef BAUD_TICK_EN
            tick_q      <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            baud_q      <= baud_d;
            baud_rate_q <= BaudRate;
`ifdef BAUD_TICK_EN
            tick_q      <= tick_d;
`endif
        end
    end

    assign BaudOut = baud_q;
`ifdef BAUD_TICK_EN
    assign BaudTick = tick_q;
`endif

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen. Expected BaudOut toggles (edge number and
// new level) are pushed to a scoreboard as stimulus is applied; a negedge
// monitor pops and compares each observed toggle.
module tb_baud_rate_gen;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] BaudRate;
    logic       BaudOut;
`ifdef BAUD_TICK_EN
    logic       BaudTick;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int   edge_n;
        logic lvl;
    } exp_t;

    exp_t sb[$];

    logic mon_en   = 1'b0;
    logic prev_out = 1'b0;

    // model of the current half-period: start edge, length, current level
    int   s;
    int   h;
    logic lvl;

    baud_rate_gen dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .BaudRate (BaudRate),
`ifdef BAUD_TICK_EN
        .BaudTick (BaudTick),
`endif
        .BaudOut  (BaudOut)
    );

    always #10 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic int half_of(input logic [1:0] r);
        case (r)
            2'b00:   return 10416;
            2'b01:   return 5208;
            2'b10:   return 2604;
            default: return 1302;
        endcase
    endfunction

    // toggle monitor / scoreboard consumer
    always @(negedge Clock) begin
        exp_t e;
        if (mon_en && (BaudOut !== prev_out)) begin
            tests++;
            assert (sb.size() != 0)
            else begin
                fails++;
                $error("FAIL unexpected_toggle edge=%0d level=%b expected no toggle", cyc, BaudOut);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                tests++;
                assert (cyc === e.edge_n)
                else begin
                    fails++;
                    $error("FAIL toggle_edge observed=%0d expected=%0d", cyc, e.edge_n);
                end
                tests++;
                assert (BaudOut === e.lvl)
                else begin
                    fails++;
                    $error("FAIL toggle_level observed=%b expected=%b", BaudOut, e.lvl);
                end
            end
        end
`ifdef BAUD_TICK_EN
        if (mon_en) begin
            tests++;
            assert (BaudTick === ((BaudOut === 1'b1) && (prev_out === 1'b0)))
            else begin
                fails++;
                $error("FAIL baud_tick edge=%0d observed=%b expected=%b", cyc, BaudTick,
                       ((BaudOut === 1'b1) && (prev_out === 1'b0)));
            end
        end
`endif
        prev_out = BaudOut;
    end

    task automatic wait_to(input int e);
        while (cyc < e) @(negedge Clock);
    endtask

    // push the next n toggles of a stable rate and advance the model
    task automatic run_toggles(input int n);
        for (int i = 1; i <= n; i++) begin
            lvl = ~lvl;
            sb.push_back('{edge_n: s + i * h, lvl: lvl});
        end
        s = s + n * h;
    endtask

    // called at a negedge: the change is seen at the next rising edge
    task automatic set_rate(input logic [1:0] r);
        BaudRate = r;
        s = cyc + 1;
        h = half_of(r);
    endtask

    task automatic check_in_reset(input string tag);
        tests++;
        assert (BaudOut === 1'b0)
        else begin
            fails++;
            $error("FAIL %s_out observed=%b expected=0", tag, BaudOut);
        end
`ifdef BAUD_TICK_EN
        tests++;
        assert (BaudTick === 1'b0)
        else begin
            fails++;
            $error("FAIL %s_tick observed=%b expected=0", tag, BaudTick);
        end
`endif
    endtask

    initial begin
        // power-up reset, 3 cycles at 19200 baud
        Reset    = 1'b1;
        BaudRate = 2'b11;
        repeat (3) begin
            @(negedge Clock);
            check_in_reset("reset");
        end
        Reset  = 1'b0;
        s      = cyc;
        h      = half_of(2'b11);
        lvl    = 1'b0;
        mon_en = 1'b1;
        run_toggles(4);

        // rate sweep 01 -> 10 -> 00
        wait_to(s);
        set_rate(2'b01);
        run_toggles(3);
        wait_to(s);
        set_rate(2'b10);
        run_toggles(5);
        wait_to(s);
        set_rate(2'b00);
        run_toggles(2);

        // mid-period change 11 -> 01 at count 700
        wait_to(s);
        set_rate(2'b11);
        run_toggles(1);
        wait_to(s + 700);
        set_rate(2'b01);
        run_toggles(1);

        // reset while BaudOut is high and the count is partway
        wait_to(s);
        set_rate(2'b11);
        run_toggles(1);
        wait_to(s + 500);
        Reset = 1'b1;
        lvl   = 1'b0;
        sb.push_back('{edge_n: cyc + 1, lvl: 1'b0});
        @(negedge Clock);
        check_in_reset("midreset");
        @(negedge Clock);
        check_in_reset("midreset");
        Reset = 1'b0;
        s     = cyc;
        h     = half_of(2'b11);
        run_toggles(2);

        // 9600 baud: tick once per 5208-cycle period when enabled
        wait_to(s);
        set_rate(2'b10);
        run_toggles(4);

        wait_to(s + 10);
        tests++;
        assert (sb.size() == 0)
        else begin
            fails++;
            $error("FAIL missing_toggles observed=%0d pending expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout observed=%0d cycles expected=completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/baud_rate_gen.md
# baud_rate_gen

Programmable baud-clock generator for the UART transmitter. It divides the system clock (50 MHz by default) into a 50 % duty-cycle square wave whose period is one bit time at one of four selectable rates: 2400, 4800, 9600 or 19200 baud. The UART-Tx shift/serializer logic consumes `BaudOut` as its bit-rate timing reference.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `CNT_W`, default 16: divider counter width. Must hold the largest half-period count.

Ports:
- `Clock`, input, 1: system clock. All logic is on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `BaudRate`, input, 2: rate select. 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
- `BaudOut`, output, 1: baud square wave, registered.
- `BaudTick`, output, 1: present only with `BAUD_TICK_EN` (see Configuration).

## Operation
- Half-period count HALF = CLK_FREQ / (2 × baud), using integer truncation.
- At defaults, HALF is 10416 for 00, 5208 for 01, 2604 for 10, and 1302 for 11.
- HALF is selected combinationally from the registered copy `BaudRateQ`, never from raw `BaudRate`.
- Counter `Cnt` increments each cycle. When `Cnt == HALF-1`:
  - `BaudOut` toggles.
  - `Cnt` returns to 0.
- Full output period is 2×HALF cycles. At defaults:
  - 2400 baud: 20832 cycles (416.64 µs).
  - 19200 baud: 2604 cycles (52.08 µs).
- Rate change: `BaudRateQ` samples `BaudRate` every cycle. On a cycle where `BaudRate != BaudRateQ`:
  - `Cnt` clears to 0.
  - `BaudOut` holds its level.
  - The first half-period at the new rate starts on the next cycle.
  - No runt toggle is ever produced on a change.
- Changing `BaudRate` back and forth restarts the count each time. There are no other side effects.
- Reset (synchronous, highest priority):
  - `Cnt` = 0 and `BaudOut` = 0.
  - `BaudRateQ` loads the current `BaudRate`.
  - `BaudTick` = 0.
- Reset asserted mid-period discards the partial count. Operation after release is identical to operation after power-up reset.

## Timing
- Reset is sampled on the rising edge of `Clock`, and all outputs are registered.
- After the last reset edge, with `BaudRate` stable, the first toggle of `BaudOut` (0→1) occurs on the HALF-th subsequent rising edge. Each later toggle occurs every HALF edges after that.
- A `BaudRate` change seen at edge k restarts counting. The next toggle is at edge k + HALF_new.
- Latency from `BaudRate` input change to a period change is 1 cycle, through `BaudRateQ`.
- `BaudOut` is glitch-free: it is driven directly from a flop.

## Configuration
- Macro: `BAUD_TICK_EN`.
- Defined:
  - Adds output `BaudTick`, a registered one-cycle pulse.
  - The pulse is high in the same cycle `BaudOut` first reads 1 after a 0→1 toggle, i.e. one pulse per bit period.
  - Reset value of `BaudTick` is 0.
- Undefined: the `BaudTick` port and its logic are absent, and `BaudOut` behaviour is unchanged.

## Test plan
- Reset: hold `Reset` = 1 for 3 cycles with `BaudRate` = 11 -> `BaudOut` = 0 throughout, and the first rising edge of `BaudOut` occurs 1302 cycles after release.
- `BaudRate` = 11 steady -> `BaudOut` toggles every 1302 cycles (26.04 µs at 20 ns clock); period 52.08 µs; high time = low time.
- Sweep rates, 250 µs or more each, in the order 01 → 10 → 00:
  - 01 -> half-period 5208 cycles.
  - 10 -> half-period 2604 cycles.
  - 00 -> half-period 10416 cycles.
- Mid-period rate change: switch 11→01 at count 700 -> no toggle at old count 1301; the next toggle is exactly 5208 cycles after the change edge; `BaudOut` level is held across the change.
- Reset mid-operation: assert `Reset` while `BaudOut` = 1 and the count is partway -> `BaudOut` = 0 next edge, and the counting restart matches the first test.
- With `BAUD_TICK_EN` and `BaudRate` = 10 -> `BaudTick` is a single-cycle pulse every 5208 cycles, aligned with each rising edge of `BaudOut`, and never during reset.
